// File: rtl/ex_hazard_alu_pkg.sv
// Shared Lapido pipeline constants: ALU opcodes, forward-select codes and the
// control bubble word injected on stall/flush.
package lapido_pkg;

    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_ADDINC   = 5'b00001;
    localparam logic [4:0] OP_INCA     = 5'b00010;
    localparam logic [4:0] OP_SUB      = 5'b00011;
    localparam logic [4:0] OP_SUBDEC   = 5'b00100;
    localparam logic [4:0] OP_DECA     = 5'b00101;
    localparam logic [4:0] OP_LSL      = 5'b00110;
    localparam logic [4:0] OP_ASR      = 5'b00111;
    localparam logic [4:0] OP_ZEROS    = 5'b01000;
    localparam logic [4:0] OP_ONES     = 5'b01001;
    localparam logic [4:0] OP_PASSA    = 5'b01010;
    localparam logic [4:0] OP_PASSNOTA = 5'b01011;
    localparam logic [4:0] OP_AND      = 5'b01100;
    localparam logic [4:0] OP_ANDNOTA  = 5'b01101;
    localparam logic [4:0] OP_NAND     = 5'b01110;
    localparam logic [4:0] OP_OR       = 5'b01111;
    localparam logic [4:0] OP_ORNOTA   = 5'b10000;
    localparam logic [4:0] OP_NOR      = 5'b10001;
    localparam logic [4:0] OP_XOR      = 5'b10010;
    localparam logic [4:0] OP_XNOR     = 5'b10011;
    localparam logic [4:0] OP_PASSB    = 5'b10100;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [14:0] CTRL_BUBBLE = 15'b000000000000110;

endpackage

// File: rtl/ex_hazard_alu_if.sv
// Execute-stage bundle: forwarding/hazard register indices, ALU operands and
// the select, stall and flag results returned to the pipeline.
interface ex_hazard_alu_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int OP_W   = 5
);
    logic              ex_mem_regWrite;
    logic [REG_W-1:0]  ex_mem_registerRD;
    logic              mem_wb_regWrite;
    logic [REG_W-1:0]  mem_wb_registerRD;
    logic [REG_W-1:0]  id_ex_registerA;
    logic [REG_W-1:0]  id_ex_registerB;
    logic              ALUSrc;
    logic [1:0]        forwardA;
    logic [1:0]        forwardB;

    logic              id_ex_memRead;
    logic [REG_W-1:0]  id_ex_registerRD;
    logic [REG_W-1:0]  if_id_registerA;
    logic [REG_W-1:0]  if_id_registerB;
    logic              branch;
    logic              enablePC;
    logic              muxSelector;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] Out;
    logic              zero;
    logic              overflow;
    logic              carry;
    logic              neg;

    modport master (
        output ex_mem_regWrite, ex_mem_registerRD, mem_wb_regWrite, mem_wb_registerRD,
        output id_ex_registerA, id_ex_registerB, ALUSrc,
        output id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB, branch,
        output A, B, opcode,
        input  forwardA, forwardB, enablePC, muxSelector,
        input  Out, zero, overflow, carry, neg
    );

    modport slave (
        input  ex_mem_regWrite, ex_mem_registerRD, mem_wb_regWrite, mem_wb_registerRD,
        input  id_ex_registerA, id_ex_registerB, ALUSrc,
        input  id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB, branch,
        input  A, B, opcode,
        output forwardA, forwardB, enablePC, muxSelector,
        output Out, zero, overflow, carry, neg
    );
endinterface

// File: rtl/ex_hazard_alu_alu.sv
// Combinational ALU: result, zero and the next values of the overflow, carry
// and neg flags. All arithmetic ops share one adder with operand/carry-in muxing.
module alu_core
    import lapido_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              nextOverflow,
    output logic              nextCarry,
    output logic              nextNeg
);
    localparam int SHW = $clog2(DATA_W);

    logic [DATA_W-1:0] addA;
    logic [DATA_W-1:0] addB;
    logic              addCin;
    logic              isArith;
    logic [DATA_W:0]   sum;

    // Subtraction is A + ~B + 1, so carry out means "no borrow".
    always_comb begin
        addA    = a;
        addB    = b;
        addCin  = 1'b0;
        isArith = 1'b1;
        case (opcode)
            OP_ADD:    ;
            OP_ADDINC: addCin = 1'b1;
            OP_INCA:   begin addB = '0; addCin = 1'b1; end
            OP_SUB:    begin addB = ~b; addCin = 1'b1; end
            OP_SUBDEC: addB = ~b;
            OP_DECA:   addB = '1;
            default:   isArith = 1'b0;
        endcase
    end

    assign sum = {1'b0, addA} + {1'b0, addB} + {{DATA_W{1'b0}}, addCin};

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD, OP_ADDINC, OP_INCA,
            OP_SUB, OP_SUBDEC, OP_DECA: result = sum[DATA_W-1:0];
            OP_LSL:      result = a << b[SHW-1:0];
            OP_ASR:      result = $signed(a) >>> b[SHW-1:0];
            OP_ZEROS:    result = '0;
            OP_ONES:     result = '1;
            OP_PASSA:    result = a;
            OP_PASSNOTA: result = ~a;
            OP_AND:      result = a & b;
            OP_ANDNOTA:  result = ~a & b;
            OP_NAND:     result = ~(a & b);
            OP_OR:       result = a | b;
            OP_ORNOTA:   result = ~a | b;
            OP_NOR:      result = ~(a | b);
            OP_XOR:      result = a ^ b;
            OP_XNOR:     result = ~(a ^ b);
            OP_PASSB:    result = b;
            default:     result = '0;
        endcase
    end

    assign zero         = (result == '0);
    assign nextNeg      = result[DATA_W-1];
    assign nextCarry    = isArith & sum[DATA_W];
    assign nextOverflow = isArith & (addA[DATA_W-1] == addB[DATA_W-1])
                                  & (sum[DATA_W-1] != addA[DATA_W-1]);

endmodule

// File: rtl/ex_hazard_alu.sv
// Lapido execute stage: operand forwarding, load-use/branch hazard detection
// and the ALU with its registered overflow/carry/neg flags.
module ex_hazard_alu
    import lapido_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int OP_W   = 5
) (
    input  logic          clock,
    input  logic          reset,
    ex_hazard_alu_if.slave bus
);
    function automatic logic regMatch(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
        return x == y;
    endfunction

    logic loadUse;
    logic nextOverflow;
    logic nextCarry;
    logic nextNeg;

    // Register 0 is not special here; EX/MEM is the younger result and wins.
    always_comb begin
        bus.forwardA = FWD_RF;
        if (bus.ex_mem_regWrite && regMatch(bus.ex_mem_registerRD, bus.id_ex_registerA))
            bus.forwardA = FWD_EXMEM;
        else if (bus.mem_wb_regWrite && regMatch(bus.mem_wb_registerRD, bus.id_ex_registerA))
            bus.forwardA = FWD_WB;

        bus.forwardB = FWD_RF;
        if (bus.ALUSrc)
            bus.forwardB = FWD_RF;
        else if (bus.ex_mem_regWrite && regMatch(bus.ex_mem_registerRD, bus.id_ex_registerB))
            bus.forwardB = FWD_EXMEM;
        else if (bus.mem_wb_regWrite && regMatch(bus.mem_wb_registerRD, bus.id_ex_registerB))
            bus.forwardB = FWD_WB;
    end

    assign loadUse = bus.id_ex_memRead &&
                     (regMatch(bus.id_ex_registerRD, bus.if_id_registerA) ||
                      regMatch(bus.id_ex_registerRD, bus.if_id_registerB));

    // A taken branch flushes the younger instructions, so a pending stall is moot.
    always_comb begin
        bus.enablePC    = 1'b1;
        bus.muxSelector = 1'b0;
        if (bus.branch) begin
            bus.muxSelector = 1'b1;
        end else if (loadUse) begin
            bus.enablePC    = 1'b0;
            bus.muxSelector = 1'b1;
        end
    end

    alu_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a            (bus.A),
        .b            (bus.B),
        .opcode       (bus.opcode),
        .result       (bus.Out),
        .zero         (bus.zero),
        .nextOverflow (nextOverflow),
        .nextCarry    (nextCarry),
        .nextNeg      (nextNeg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.overflow <= 1'b0;
            bus.carry    <= 1'b0;
            bus.neg      <= 1'b0;
        end else begin
            bus.overflow <= nextOverflow;
            bus.carry    <= nextCarry;
            bus.neg      <= nextNeg;
        end
    end

endmodule

// File: tb/tb_ex_hazard_alu.sv
// Scoreboard bench for ex_hazard_alu: expectations are queued as each vector is
// driven and popped against the combinational outputs and the following flag update.
module tb_ex_hazard_alu;
    import lapido_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ex_hazard_alu_if bus();

    ex_hazard_alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic popCheck(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            checkVal(e.tag, obs, e.val);
        end
    endtask

    function automatic void pushExp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    // Reference ALU written from the operation table with wide signed math.
    function automatic void refAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic v);
        longint      sa = $signed(a);
        longint      sbv = $signed(b);
        longint      t = 0;
        longint      maxv = 64'sh7FFFFFFF;
        longint      minv = -64'sh80000000;
        logic [63:0] u = 64'd0;
        logic        arith = 1'b1;
        logic [4:0]  sh = b[4:0];
        r = 32'd0;
        c = 1'b0;
        case (op)
            OP_ADD:    begin u = 64'(a) + 64'(b);         r = u[31:0]; c = u[32]; t = sa + sbv; end
            OP_ADDINC: begin u = 64'(a) + 64'(b) + 64'd1; r = u[31:0]; c = u[32]; t = sa + sbv + 1; end
            OP_INCA:   begin r = a + 32'd1;     c = (a == 32'hFFFFFFFF); t = sa + 1; end
            OP_SUB:    begin r = a - b;         c = (a >= b);            t = sa - sbv; end
            OP_SUBDEC: begin r = a - b - 32'd1; c = (a > b);             t = sa - sbv - 1; end
            OP_DECA:   begin r = a - 32'd1;     c = (a != 32'd0);        t = sa - 1; end
            default: begin
                arith = 1'b0;
                case (op)
                    OP_LSL:      r = a << sh;
                    OP_ASR:      r = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
                    OP_ONES:     r = 32'hFFFFFFFF;
                    OP_PASSA:    r = a;
                    OP_PASSNOTA: r = ~a;
                    OP_AND:      r = a & b;
                    OP_ANDNOTA:  r = ~a & b;
                    OP_NAND:     r = ~(a & b);
                    OP_OR:       r = a | b;
                    OP_ORNOTA:   r = ~a | b;
                    OP_NOR:      r = ~(a | b);
                    OP_XOR:      r = a ^ b;
                    OP_XNOR:     r = ~(a ^ b);
                    OP_PASSB:    r = b;
                    default:     r = 32'd0;
                endcase
            end
        endcase
        v = arith && (t > maxv || t < minv);
    endfunction

    task automatic setFwd(input logic exW, input logic [3:0] exRd, input logic wbW, input logic [3:0] wbRd,
                          input logic [3:0] ra, input logic [3:0] rb, input logic aluSrc);
        bus.ex_mem_regWrite   = exW;
        bus.ex_mem_registerRD = exRd;
        bus.mem_wb_regWrite   = wbW;
        bus.mem_wb_registerRD = wbRd;
        bus.id_ex_registerA   = ra;
        bus.id_ex_registerB   = rb;
        bus.ALUSrc            = aluSrc;
    endtask

    task automatic setHaz(input logic memRead, input logic [3:0] rd, input logic [3:0] ifA,
                          input logic [3:0] ifB, input logic br);
        bus.id_ex_memRead    = memRead;
        bus.id_ex_registerRD = rd;
        bus.if_id_registerA  = ifA;
        bus.if_id_registerB  = ifB;
        bus.branch           = br;
    endtask

    task automatic setAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
    endtask

    // Called right after a rising edge with inputs already driven; returns one edge later.
    task automatic applyAndCheck();
        logic [1:0]  fa, fb;
        logic        en, mux, c, v;
        logic [31:0] r;

        fa = 2'b00;
        if (bus.ex_mem_regWrite && bus.ex_mem_registerRD == bus.id_ex_registerA)      fa = 2'b10;
        else if (bus.mem_wb_regWrite && bus.mem_wb_registerRD == bus.id_ex_registerA) fa = 2'b01;
        fb = 2'b00;
        if (!bus.ALUSrc) begin
            if (bus.ex_mem_regWrite && bus.ex_mem_registerRD == bus.id_ex_registerB)      fb = 2'b10;
            else if (bus.mem_wb_regWrite && bus.mem_wb_registerRD == bus.id_ex_registerB) fb = 2'b01;
        end
        if (bus.branch) begin
            en = 1'b1; mux = 1'b1;
        end else if (bus.id_ex_memRead && (bus.id_ex_registerRD == bus.if_id_registerA ||
                                           bus.id_ex_registerRD == bus.if_id_registerB)) begin
            en = 1'b0; mux = 1'b1;
        end else begin
            en = 1'b1; mux = 1'b0;
        end
        refAlu(bus.opcode, bus.A, bus.B, r, c, v);

        pushExp("forwardA", 32'(fa));
        pushExp("forwardB", 32'(fb));
        pushExp("enablePC", 32'(en));
        pushExp("muxSelector", 32'(mux));
        pushExp("Out", r);
        pushExp("zero", 32'(r == 32'd0));
        pushExp("overflow", 32'(v));
        pushExp("carry", 32'(c));
        pushExp("neg", 32'(r[31]));

        #3;
        popCheck(32'(bus.forwardA));
        popCheck(32'(bus.forwardB));
        popCheck(32'(bus.enablePC));
        popCheck(32'(bus.muxSelector));
        popCheck(bus.Out);
        popCheck(32'(bus.zero));
        @(posedge clock);
        #1;
        popCheck(32'(bus.overflow));
        popCheck(32'(bus.carry));
        popCheck(32'(bus.neg));
    endtask

    initial begin
        setFwd(1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        setHaz(1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        setAlu(OP_ADD, 32'h7FFFFFFF, 32'd1);

        // Flags held clear while reset is low, even across clock edges.
        @(posedge clock);
        #1;
        checkVal("reset_overflow", 32'(bus.overflow), 32'd0);
        checkVal("reset_carry", 32'(bus.carry), 32'd0);
        checkVal("reset_neg", 32'(bus.neg), 32'd0);
        checkVal("reset_comb_Out", bus.Out, 32'h80000000);
        reset = 1'b1;

        setAlu(OP_ADD, 32'd0, 32'd0);
        setFwd(1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 4'd3, 1'b0);
        applyAndCheck();
        setFwd(1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1);
        applyAndCheck();
        setFwd(1'b0, 4'd3, 1'b1, 4'd3, 4'd3, 4'd3, 1'b0);
        applyAndCheck();
        setFwd(1'b1, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
        applyAndCheck();
        setFwd(1'b1, 4'd2, 1'b1, 4'd5, 4'd5, 4'd2, 1'b0);
        applyAndCheck();

        setFwd(1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        setHaz(1'b1, 4'd5, 4'd5, 4'd9, 1'b0);
        applyAndCheck();
        setHaz(1'b1, 4'd5, 4'd6, 4'd7, 1'b0);
        applyAndCheck();
        setHaz(1'b1, 4'd5, 4'd6, 4'd5, 1'b0);
        applyAndCheck();
        setHaz(1'b1, 4'd5, 4'd5, 4'd9, 1'b1);
        applyAndCheck();
        setHaz(1'b0, 4'd5, 4'd5, 4'd5, 1'b0);
        applyAndCheck();

        setHaz(1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        setAlu(OP_ADD, 32'h7FFFFFFF, 32'd1);
        applyAndCheck();

        // Asynchronous clear between edges; combinational result stays put.
        #2;
        reset = 1'b0;
        #1;
        checkVal("async_clr_overflow", 32'(bus.overflow), 32'd0);
        checkVal("async_clr_carry", 32'(bus.carry), 32'd0);
        checkVal("async_clr_neg", 32'(bus.neg), 32'd0);
        checkVal("async_clr_Out", bus.Out, 32'h80000000);
        @(posedge clock);
        #1;
        checkVal("held_clr_overflow", 32'(bus.overflow), 32'd0);
        checkVal("held_clr_neg", 32'(bus.neg), 32'd0);
        reset = 1'b1;

        setAlu(OP_SUB, 32'h1234, 32'h1234);           applyAndCheck();
        setAlu(OP_LSL, 32'd1, 32'd31);                applyAndCheck();
        setAlu(OP_ASR, 32'h80000000, 32'd4);          applyAndCheck();
        setAlu(OP_LSL, 32'hA5A5A5A5, 32'd32);         applyAndCheck();
        setAlu(OP_ASR, 32'h80000000, 32'h0000003F);   applyAndCheck();
        setAlu(OP_INCA, 32'hFFFFFFFF, 32'd7);         applyAndCheck();
        setAlu(OP_DECA, 32'd0, 32'd7);                applyAndCheck();
        setAlu(OP_DECA, 32'h80000000, 32'd0);         applyAndCheck();
        setAlu(OP_SUB, 32'd0, 32'd1);                 applyAndCheck();
        setAlu(OP_SUB, 32'h80000000, 32'd1);          applyAndCheck();
        setAlu(OP_SUBDEC, 32'd5, 32'd5);              applyAndCheck();
        setAlu(OP_SUBDEC, 32'd6, 32'd5);              applyAndCheck();
        setAlu(OP_ADDINC, 32'hFFFFFFFF, 32'd0);       applyAndCheck();
        setAlu(OP_ADD, 32'h80000000, 32'h80000000);   applyAndCheck();
        setAlu(OP_ONES, 32'd0, 32'd0);                applyAndCheck();
        setAlu(5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF); applyAndCheck();

        for (int op = 0; op < 32; op++) begin
            setAlu(5'(op), $urandom(), $urandom());
            setFwd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
            setHaz(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            applyAndCheck();
        end

        checkVal("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ex_hazard_alu.md
# ex_hazard_alu

Execute-stage datapath core of the Lapido 5-stage pipeline. It combines three functions: the forwarding unit that selects ALU operand sources, the hazard detection unit that stalls on load-use and flushes on taken branch, and the 32-bit ALU with a flag register. It sits between the id_ex and ex_mem pipeline registers. The surrounding operand muxes consume its forward selects, and the PC and control-bubble mux consume its hazard outputs.

## Interface
Parameters:
- DATA_W, 32, ALU datapath width
- REG_W, 4, register-index width (16 registers)
- OP_W, 5, ALU opcode width

Ports:
- clock  in  1  system clock; flags update on its rising edge
- reset  in  1  asynchronous, active-low; clears the flag register
- ex_mem_regWrite  in  1  EX/MEM stage writes a register
- ex_mem_registerRD  in  REG_W  EX/MEM destination register
- mem_wb_regWrite  in  1  MEM/WB stage writes a register
- mem_wb_registerRD  in  REG_W  MEM/WB destination register
- id_ex_registerA, id_ex_registerB  in  REG_W  EX-stage source registers
- ALUSrc  in  1  EX operand B is the immediate
- forwardA, forwardB  out  2  operand selects: 00 register file, 01 MEM/WB writeback value, 10 EX/MEM ALU result
- id_ex_memRead  in  1  EX-stage instruction is a load
- id_ex_registerRD  in  REG_W  EX-stage destination register
- if_id_registerA, if_id_registerB  in  REG_W  ID-stage source registers
- branch  in  1  branch taken (zero & branch_id_ex)
- enablePC  out  1  1 = PC may advance
- muxSelector  out  1  1 = inject control bubble 15'b000000000000110
- A, B  in  DATA_W  ALU operands (already forwarded)
- opcode  in  OP_W  ALU operation
- Out  out  DATA_W  ALU result
- zero  out  1  Out == 0
- overflow, carry, neg  out  1  registered flags

## Operation
- Forwarding A:
  - 10 if ex_mem_regWrite and ex_mem_registerRD == id_ex_registerA.
  - Otherwise 01 if mem_wb_regWrite and mem_wb_registerRD == id_ex_registerA.
  - Otherwise 00.
- Forwarding B: same rule using id_ex_registerB, but forced to 00 when ALUSrc = 1.
- Forwarding priority: EX/MEM wins over MEM/WB when both match.
- Register 0 is an ordinary register with no exclusion.
- Hazard detection, load-use:
  - Condition: id_ex_memRead and id_ex_registerRD equals if_id_registerA or if_id_registerB.
  - Response: enablePC = 0, muxSelector = 1.
- Hazard detection, branch = 1: enablePC = 1, muxSelector = 1 (flush). Branch has priority over load-use.
- Otherwise enablePC = 1, muxSelector = 0.
- ALU opcodes (opcode, result):
  - 00000 ADD A+B; 00001 ADDINC A+B+1; 00010 INCA A+1
  - 00011 SUB A−B; 00100 SUBDEC A−B−1; 00101 DECA A−1
  - 00110 LSL A<<B[4:0]; 00111 ASR A>>>B[4:0]; 01000 ZEROS 0; 01001 ONES all-1
  - 01010 PASSA A; 01011 PASSNOTA ~A; 01100 AND; 01101 ANDNOTA ~A&B; 01110 NAND
  - 01111 OR; 10000 ORNOTA ~A|B; 10001 NOR; 10010 XOR; 10011 XNOR; 10100 PASSB B
  - all other codes give 0.
- Arithmetic flags:
  - carry = bit 32 of the 33-bit sum; subtraction is computed as A+~B+1, so carry=1 means no borrow.
  - overflow = signed two's-complement overflow.
- Non-arithmetic ops: carry = overflow = 0.
- neg = Out[31]. zero = (Out == 0).

## Timing
- FU, HDU, Out and zero are purely combinational with zero latency. zero must be valid in the same cycle for branch resolution.
- overflow, carry and neg are captured from the next-state flag values on every rising clock edge.
- reset low clears all three flags to 0 immediately, independent of the clock, and holds them at 0 while asserted. Combinational outputs are unaffected by reset.
- Simultaneous load-use and taken branch resolve to the branch response.
- Shift amounts of 0 return A unchanged. Shift amounts ≥ 32 are not possible because only B[4:0] is used.

## Structure
- Shared package lapido_pkg holds:
  - ALU opcode localparams (ADD … PASSB);
  - forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EXMEM = 2'b10;
  - the bubble constant 15'b000000000000110.
- One natural sub-module: alu_core, holding the combinational result, zero and next-flag logic.
- Forwarding and hazard logic stay inline in the top level.

## Test plan
- Forwarding: ex_mem regWrite=1 rd=3, mem_wb regWrite=1 rd=3, id_ex A=3 B=3 ALUSrc=0 → forwardA=10, forwardB=10. Same inputs with ALUSrc=1 → forwardB=00. Clearing ex_mem regWrite → forwardA=01.
- Load-use stall: id_ex_memRead=1, rd=5, if_id A=5, branch=0 → enablePC=0, muxSelector=1. Changing if_id A to 6 and B to 7 → enablePC=1, muxSelector=0.
- Branch flush: branch=1 together with a load-use match → enablePC=1, muxSelector=1.
- ADD overflow: opcode 00000, A=32'h7FFFFFFF, B=1 → Out=32'h80000000, zero=0. After the next rising edge: overflow=1, neg=1, carry=0.
- SUB equal: opcode 00011, A=B=32'h1234 → Out=0, zero=1. After the next rising edge: carry=1, overflow=0.
- Logic, shift and reset:
  - opcode 00110, A=1, B=31 → Out=32'h80000000.
  - opcode 00111, A=32'h80000000, B=4 → Out=32'hF8000000.
  - Asserting reset low between clock edges clears all flags immediately.
